// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry controller signal bundle: key events and CPU handshake in,
// nibble select, echo value and committed data out.
interface keypad_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        cpu_ack;
  logic [1:0]  kbrps;
  logic [15:0] entry_value;
  logic [2:0]  digit_cnt;
  logic        data_ready;
  logic [15:0] data_out;
  logic        overrun;

  modport master (
    output key_valid, key_code, cpu_ack,
    input  kbrps, entry_value, digit_cnt, data_ready, data_out, overrun
  );

  modport slave (
    input  key_valid, key_code, cpu_ack,
    output kbrps, entry_value, digit_cnt, data_ready, data_out, overrun
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Multi-digit hex keypad entry sequencer with CPU ready/ack handoff.
// Optional backspace key enabled by defining KEYPAD_BKSP_EN.
module keypad_entry_ctrl #(
  parameter logic [3:0] COMMIT_KEY = 4'hE,
  parameter logic [3:0] CLEAR_KEY  = 4'hF
`ifdef KEYPAD_BKSP_EN
  ,
  parameter logic [3:0] BKSP_KEY   = 4'hD
`endif
) (
  input logic                 clk,
  input logic                 rst,
  keypad_entry_ctrl_if.slave  kif
);

  localparam int unsigned VAL_W = 16;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   entry_q, entry_d;
  logic [VAL_W-1:0]   dout_q, dout_d;
  logic               ready_q, ready_d;
  logic               ovr_q, ovr_d;
  logic [1:0]         kbrps_q, kbrps_d;
  logic [1:0]         idx;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      entry_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      kbrps_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      kbrps_q <= kbrps_d;
    end
  end

  // Next-state and datapath update; ack is applied before a same-cycle commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    idx     = cnt_q[1:0];

    if (kif.cpu_ack) ready_d = 1'b0;

    case (state_q)
      IDLE, ENTRY, FULL: begin
        if (kif.key_valid) begin
          if (kif.key_code == CLEAR_KEY) begin
            entry_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (kif.key_code == COMMIT_KEY) begin
            if (state_q != IDLE) begin
              if (ready_d) begin
                ovr_d = 1'b1;
              end else begin
                dout_d  = entry_q;
                ready_d = 1'b1;
              end
              entry_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
`ifdef KEYPAD_BKSP_EN
          else if (kif.key_code == BKSP_KEY) begin
            if (state_q != IDLE) begin
              idx                      = 2'(cnt_q - 3'd1);
              entry_d[{idx, 2'b00} +: 4] = 4'h0;
              cnt_d                    = cnt_q - 3'd1;
              state_d                  = (cnt_d == 3'd0) ? IDLE : ENTRY;
            end
          end
`endif
          else if (state_q != FULL) begin
            entry_d[{idx, 2'b00} +: 4] = kif.key_code;
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd3) ? FULL : ENTRY;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        entry_d = '0;
      end
    endcase

    kbrps_d = (cnt_d == 3'd4) ? 2'b11 : cnt_d[1:0];
  end

  assign kif.kbrps       = kbrps_q;
  assign kif.entry_value = entry_q;
  assign kif.digit_cnt   = cnt_q;
  assign kif.data_ready  = ready_q;
  assign kif.data_out    = dout_q;
  assign kif.overrun     = ovr_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Table-driven scoreboard bench for keypad_entry_ctrl, plus reset,
// ack/commit collision and backspace sequences.
module tb_keypad_entry_ctrl;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        ack;
    logic [1:0]  kbrps;
    logic [15:0] ev;
    logic [2:0]  cnt;
    logic        rdy;
    logic [15:0] dout;
    logic        ovr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t exp_q[$];
  vec_t tbl[25];

  keypad_entry_ctrl_if kif();

  keypad_entry_ctrl dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic kv, logic [3:0] kc, logic ack, logic [1:0] kb,
                              logic [15:0] ev, logic [2:0] cnt, logic rdy,
                              logic [15:0] dout, logic ovr);
    vec_t v;
    v.kv = kv; v.kc = kc; v.ack = ack; v.kbrps = kb; v.ev = ev;
    v.cnt = cnt; v.rdy = rdy; v.dout = dout; v.ovr = ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".kbrps"},       16'(kif.kbrps),       16'(e.kbrps));
    check({tag, ".entry_value"}, kif.entry_value,      e.ev);
    check({tag, ".digit_cnt"},   16'(kif.digit_cnt),   16'(e.cnt));
    check({tag, ".data_ready"},  16'(kif.data_ready),  16'(e.rdy));
    check({tag, ".data_out"},    kif.data_out,         e.dout);
    check({tag, ".overrun"},     16'(kif.overrun),     16'(e.ovr));
  endtask

  // Drive one cycle of stimulus; expectation queued now, popped after the edge
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    @(negedge clk);
    kif.key_valid = v.kv;
    kif.key_code  = v.kc;
    kif.cpu_ack   = v.ack;
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
    kif.cpu_ack   = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    vec_t zero;
    logic [15:0] bk_ev_d, bk_ev_3, bk_dout;
    logic [2:0]  bk_cnt_d, bk_cnt_3;
    logic [1:0]  bk_kb_d, bk_kb_3;

    checks = 0;
    failures = 0;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    kif.cpu_ack   = 1'b0;
    rst = 1'b0;
    zero = mk(0, 4'h0, 0, 2'd0, 16'h0000, 3'd0, 0, 16'h0000, 0);

    tbl[0]  = mk(1, 4'h1, 0, 2'd1, 16'h0001, 3'd1, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 4'h2, 0, 2'd2, 16'h0021, 3'd2, 0, 16'h0000, 0);
    tbl[2]  = mk(1, 4'h3, 0, 2'd3, 16'h0321, 3'd3, 0, 16'h0000, 0);
    tbl[3]  = mk(1, 4'h4, 0, 2'd3, 16'h4321, 3'd4, 0, 16'h0000, 0);
    tbl[4]  = mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h4321, 0);
    tbl[5]  = mk(0, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h4321, 0);
    tbl[6]  = mk(1, 4'h5, 0, 2'd1, 16'h0005, 3'd1, 1, 16'h4321, 0);
    tbl[7]  = mk(1, 4'h6, 0, 2'd2, 16'h0065, 3'd2, 1, 16'h4321, 0);
    tbl[8]  = mk(1, 4'h7, 0, 2'd3, 16'h0765, 3'd3, 1, 16'h4321, 0);
    tbl[9]  = mk(1, 4'h8, 0, 2'd3, 16'h8765, 3'd4, 1, 16'h4321, 0);
    tbl[10] = mk(1, 4'h9, 0, 2'd3, 16'h8765, 3'd4, 1, 16'h4321, 0);
    tbl[11] = mk(1, 4'hF, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h4321, 0);
    tbl[12] = mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h4321, 0);
    tbl[13] = mk(1, 4'h1, 0, 2'd1, 16'h0001, 3'd1, 1, 16'h4321, 0);
    tbl[14] = mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h4321, 1);
    tbl[15] = mk(0, 4'h0, 1, 2'd0, 16'h0000, 3'd0, 0, 16'h4321, 1);
    tbl[16] = mk(0, 4'h0, 1, 2'd0, 16'h0000, 3'd0, 0, 16'h4321, 1);
    tbl[17] = mk(1, 4'hB, 0, 2'd1, 16'h000B, 3'd1, 0, 16'h4321, 1);
    tbl[18] = mk(1, 4'hA, 0, 2'd2, 16'h00AB, 3'd2, 0, 16'h4321, 1);
    tbl[19] = mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h00AB, 1);
    tbl[20] = mk(1, 4'hC, 0, 2'd1, 16'h000C, 3'd1, 1, 16'h00AB, 1);
    tbl[21] = mk(1, 4'hE, 1, 2'd0, 16'h0000, 3'd0, 1, 16'h000C, 1);
    tbl[22] = mk(0, 4'h0, 1, 2'd0, 16'h0000, 3'd0, 0, 16'h000C, 1);
    tbl[23] = mk(1, 4'h7, 0, 2'd1, 16'h0007, 3'd1, 0, 16'h000C, 1);
    tbl[24] = mk(1, 4'hF, 0, 2'd0, 16'h0000, 3'd0, 0, 16'h000C, 1);

    #3;
    check_all("reset", zero);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Async reset mid-entry with two digits held
    step("pre_rst1", mk(1, 4'h1, 0, 2'd1, 16'h0001, 3'd1, 0, 16'h000C, 1));
    step("pre_rst2", mk(1, 4'h2, 0, 2'd2, 16'h0021, 3'd2, 0, 16'h000C, 1));
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", zero);
    @(posedge clk);
    #1;
    check_all("rst_held", zero);
    @(negedge clk);
    rst = 1'b1;

    // Ack and commit in the same cycle while a value is pending
    step("col_d1",  mk(1, 4'h1, 0, 2'd1, 16'h0001, 3'd1, 0, 16'h0000, 0));
    step("col_c1",  mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, 16'h0001, 0));
    step("col_dB",  mk(1, 4'hB, 0, 2'd1, 16'h000B, 3'd1, 1, 16'h0001, 0));
    step("col_dA",  mk(1, 4'hA, 0, 2'd2, 16'h00AB, 3'd2, 1, 16'h0001, 0));
    step("col_ack", mk(1, 4'hE, 1, 2'd0, 16'h0000, 3'd0, 1, 16'h00AB, 0));
    step("col_clr", mk(0, 4'h0, 1, 2'd0, 16'h0000, 3'd0, 0, 16'h00AB, 0));

    // Backspace key: editing key when enabled, plain digit otherwise
`ifdef KEYPAD_BKSP_EN
    bk_kb_d = 2'd1; bk_ev_d = 16'h0001; bk_cnt_d = 3'd1;
    bk_kb_3 = 2'd2; bk_ev_3 = 16'h0031; bk_cnt_3 = 3'd2;
    bk_dout = 16'h0031;
`else
    bk_kb_d = 2'd3; bk_ev_d = 16'h0D21; bk_cnt_d = 3'd3;
    bk_kb_3 = 2'd3; bk_ev_3 = 16'h3D21; bk_cnt_3 = 3'd4;
    bk_dout = 16'h3D21;
`endif
    step("bk_1", mk(1, 4'h1, 0, 2'd1, 16'h0001, 3'd1, 0, 16'h00AB, 0));
    step("bk_2", mk(1, 4'h2, 0, 2'd2, 16'h0021, 3'd2, 0, 16'h00AB, 0));
    step("bk_D", mk(1, 4'hD, 0, bk_kb_d, bk_ev_d, bk_cnt_d, 0, 16'h00AB, 0));
    step("bk_3", mk(1, 4'h3, 0, bk_kb_3, bk_ev_3, bk_cnt_3, 0, 16'h00AB, 0));
    step("bk_E", mk(1, 4'hE, 0, 2'd0, 16'h0000, 3'd0, 1, bk_dout, 0));

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
